// File: rtl/serial_tx_arbiter_pkg.sv
// Shared types for the serial transmit arbiter.
// Frame sequencer states used by the top-level FSM.
package serial_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/serial_tx_arbiter_if.sv
// Requester word handshake plus the shared serial lane.
// The arbiter takes the slave side; word producers and lane consumers take the master side.
interface serial_tx_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    localparam int SRC_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   busy;
    logic                   serial_valid;
    logic                   serial_data;
    logic                   serial_first;
    logic                   serial_last;
    logic [SRC_W-1:0]       serial_src;

    modport slave (
        input  req_valid, req_data,
        output req_ready, busy, serial_valid, serial_data,
               serial_first, serial_last, serial_src
    );

    modport master (
        output req_valid, req_data,
        input  req_ready, busy, serial_valid, serial_data,
               serial_first, serial_last, serial_src
    );

endinterface

// File: rtl/serial_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int SRC_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SRC_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [SRC_W-1:0] grant_idx,
    output logic             any_grant
);

    int               cand;
    logic [SRC_W-1:0] cand_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // explicit wrap so non-power-of-2 N_REQ never indexes past the last requester
            cand = int'(ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = SRC_W'(cand);
            if (!any_grant && req[cand_idx]) begin
                any_grant       = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Round-robin sharing of one LSB-first serial lane among N_REQ word requesters.
//
//   state | meaning
//   IDLE  | lane free, accepting a word from the granted requester
//   SHIFT | shifting the captured word out, one bit per cycle
//   GAP   | forced idle between frames, no grants
module serial_tx_arbiter
    import serial_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_tx_arbiter_if.slave  bus
);

    localparam int SRC_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(WIDTH);
    localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP);

    arb_state_t        state;
    logic [WIDTH-1:0]  shift_reg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [SRC_W-1:0]  ptr;
    logic [SRC_W-1:0]  src;
    logic              busy_q;
    logic              valid_q;
    logic              first_q;
    logic              last_q;

    logic [N_REQ-1:0]  grant;
    logic [SRC_W-1:0]  grant_idx;
    logic              any_grant;
    logic              last_bit;
    logic              accept_win;
    logic              accept;
    logic [WIDTH-1:0]  words [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            words[i] = bus.req_data[i*WIDTH +: WIDTH];
        end
    end

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req       (bus.req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign last_bit   = (state == SHIFT) && (bit_cnt == CNT_W'(WIDTH - 1));
    // rst_n gates the window so no word is handed over while reset is held
    assign accept_win = rst_n && ((state == IDLE) || (last_bit && (GAP == 0)));
    assign accept     = accept_win && any_grant;

    assign bus.req_ready    = accept_win ? grant : '0;
    assign bus.busy         = busy_q;
    assign bus.serial_valid = valid_q;
    assign bus.serial_data  = shift_reg[0];
    assign bus.serial_first = first_q;
    assign bus.serial_last  = last_q;
    assign bus.serial_src   = src;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            ptr       <= '0;
            src       <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
        end else if (accept) begin
            state     <= SHIFT;
            shift_reg <= words[grant_idx];
            bit_cnt   <= '0;
            src       <= grant_idx;
            ptr       <= (grant_idx == SRC_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            busy_q    <= 1'b1;
            valid_q   <= 1'b1;
            first_q   <= 1'b1;
            last_q    <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    // zero-fill leaves serial_data low once the frame has drained
                    shift_reg <= shift_reg >> 1;
                    first_q   <= 1'b0;
                    if (last_bit) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        if (GAP > 0) begin
                            state   <= serial_arb_pkg::GAP;
                            gap_cnt <= GAP_W'(GAP - 1);
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        last_q  <= (bit_cnt == CNT_W'(WIDTH - 2));
                    end
                end
                serial_arb_pkg::GAP: begin
                    if (gap_cnt == '0) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
